// File: rtl/dcache_flush_seq.sv
// dcache_flush_seq
//
// Purpose:
//   Sequences a data-cache flush or fence. A flush walks every (set, way)
//   line of the D$. It issues one writeback op per line and waits for the
//   cache to grant each op. It then waits for the write buffer to drain
//   and pulses a completion ack.
//   A fence with FlushOnFence=0 skips the walk and only drains the write
//   buffer. Requests that arrive while the sequencer is busy are remembered
//   in two pending flags. They are serviced back-to-back after the current
//   operation completes.
//
// Parameters:
//   NumSets           D$ sets walked per flush (power of two, >= 2)
//   NumWays           D$ ways per set (power of two, >= 2)
//   FlushOnFence      1: a fence performs a full line walk
//                     0: a fence only drains the write buffer
//   InvalidateOnFlush value presented on line_inv_o during the walk
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   fence_i       fence request pulse from commit
//   flush_i       explicit flush request pulse
//   line_req_o    per-line flush op valid
//   line_set_o    set index of the current op
//   line_way_o    way index of the current op
//   line_inv_o    invalidate line after writeback
//   line_gnt_i    cache accepts the current op
//   wbuf_empty_i  write buffer fully drained
//   busy_o        sequencer not idle
//   flush_ack_o   one-cycle completion pulse

module dcache_flush_seq #(
  parameter int unsigned NumSets           = 256,
  parameter int unsigned NumWays           = 8,
  parameter bit          FlushOnFence      = 1'b0,
  parameter bit          InvalidateOnFlush = 1'b0,
  localparam int unsigned SW               = $clog2(NumSets),
  localparam int unsigned WW               = $clog2(NumWays)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fence_i,
  input  logic          flush_i,
  output logic          line_req_o,
  output logic [SW-1:0] line_set_o,
  output logic [WW-1:0] line_way_o,
  output logic          line_inv_o,
  input  logic          line_gnt_i,
  input  logic          wbuf_empty_i,
  output logic          busy_o,
  output logic          flush_ack_o
);

  typedef enum logic [1:0] {
    Idle,
    Walk,
    Drain,
    Done
  } state_e;

  localparam logic [SW-1:0] LastSet = SW'(NumSets - 1);
  localparam logic [WW-1:0] LastWay = WW'(NumWays - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic          pendFlush_q, pendFlush_d;
  logic          pendFence_q, pendFence_d;

  // A flush always walks the cache. A fence walks only when FlushOnFence is set.
  // If flush and fence arrive together, the pulse counts as a walk request.
  logic walkReq;
  logic fenceOnly;

  assign walkReq   = flush_i | (fence_i & FlushOnFence);
  assign fenceOnly = fence_i & ~walkReq;

  // State register. Reset has priority, so any request present during a
  // reset cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      set_q       <= '0;
      way_q       <= '0;
      pendFlush_q <= 1'b0;
      pendFence_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      way_q       <= way_d;
      pendFlush_q <= pendFlush_d;
      pendFence_q <= pendFence_d;
    end
  end

  // Next-state logic.
  // In Done, the pending flags include any request arriving in that same
  // cycle, so a late pulse is still serviced immediately. A pending flush
  // wins over a pending fence. Only the serviced flag is cleared.
  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    way_d       = way_q;
    pendFlush_d = pendFlush_q;
    pendFence_d = pendFence_q;

    if (state_q != Idle) begin
      pendFlush_d = pendFlush_q | walkReq;
      pendFence_d = pendFence_q | fenceOnly;
    end

    unique case (state_q)
      Idle: begin
        if (walkReq) begin
          state_d = Walk;
          set_d   = '0;
          way_d   = '0;
        end else if (fence_i) begin
          state_d = Drain;
        end
      end
      Walk: begin
        // Way is the fast counter. The set advances when the way wraps.
        if (line_gnt_i) begin
          if (way_q == LastWay) begin
            way_d = '0;
            if (set_q == LastSet) begin
              set_d   = '0;
              state_d = Drain;
            end else begin
              set_d = set_q + 1'b1;
            end
          end else begin
            way_d = way_q + 1'b1;
          end
        end
      end
      Drain: begin
        if (wbuf_empty_i) begin
          state_d = Done;
        end
      end
      Done: begin
        if (pendFlush_d) begin
          state_d     = Walk;
          set_d       = '0;
          way_d       = '0;
          pendFlush_d = 1'b0;
        end else if (pendFence_d) begin
          state_d     = Drain;
          pendFence_d = 1'b0;
        end else begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Line op outputs are forced to zero outside the walk, so the cache
  // never sees stale indices.
  assign line_req_o  = (state_q == Walk);
  assign line_set_o  = line_req_o ? set_q : '0;
  assign line_way_o  = line_req_o ? way_q : '0;
  assign line_inv_o  = line_req_o & InvalidateOnFlush;
  assign busy_o      = (state_q != Idle);
  assign flush_ack_o = (state_q == Done);

endmodule

// File: tb/tb_dcache_flush_seq.sv
// tb_dcache_flush_seq
//
// Two sequencers (NumSets=4, NumWays=2) share one set of stimulus.
//   dutA: FlushOnFence=0, InvalidateOnFlush=1
//   dutB: FlushOnFence=1, InvalidateOnFlush=0
// A behavioural model tracks each instance as a phase plus a linear line
// index. The compare process checks every DUT output against that model
// on each falling edge. The directed sections add literal cycle-exact
// expectations, then a randomized section runs.

module tb_dcache_flush_seq;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int N  = NS * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fence, flush, gnt, wbe;

  logic       reqA, invA, busyA, ackA;
  logic [1:0] setA;
  logic [0:0] wayA;
  logic       reqB, invB, busyB, ackB;
  logic [1:0] setB;
  logic [0:0] wayB;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  dcache_flush_seq #(
    .NumSets(NS), .NumWays(NW), .FlushOnFence(1'b0), .InvalidateOnFlush(1'b1)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .fence_i(fence), .flush_i(flush),
    .line_req_o(reqA), .line_set_o(setA), .line_way_o(wayA), .line_inv_o(invA),
    .line_gnt_i(gnt), .wbuf_empty_i(wbe), .busy_o(busyA), .flush_ack_o(ackA)
  );

  dcache_flush_seq #(
    .NumSets(NS), .NumWays(NW), .FlushOnFence(1'b1), .InvalidateOnFlush(1'b0)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .fence_i(fence), .flush_i(flush),
    .line_req_o(reqB), .line_set_o(setB), .line_way_o(wayB), .line_inv_o(invB),
    .line_gnt_i(gnt), .wbuf_empty_i(wbe), .busy_o(busyB), .flush_ack_o(ackB)
  );

  // Model: ph 0=idle 1=walk 2=drain 3=done; k = lines already granted.
  typedef struct {
    int ph;
    int k;
    bit pf;
    bit pe;
  } model_t;

  model_t mA, mB;

  function automatic model_t nextModel(model_t m, bit fof, bit fe, bit fl, bit g, bit w, bit r);
    model_t n;
    bit wr;
    bit fo;
    n  = m;
    wr = fl | (fe & fof);
    fo = fe & !wr;
    if (r) begin
      n.ph = 0; n.k = 0; n.pf = 0; n.pe = 0;
      return n;
    end
    if (m.ph != 0) begin
      n.pf = m.pf | wr;
      n.pe = m.pe | fo;
    end
    case (m.ph)
      0: begin
        if (wr) begin n.ph = 1; n.k = 0; end
        else if (fe) n.ph = 2;
      end
      1: begin
        if (g) begin
          n.k = (m.k + 1) % N;
          if (m.k == N - 1) n.ph = 2;
        end
      end
      2: if (w) n.ph = 3;
      default: begin
        if (n.pf) begin n.ph = 1; n.k = 0; n.pf = 0; end
        else if (n.pe) begin n.ph = 2; n.pe = 0; end
        else n.ph = 0;
      end
    endcase
    return n;
  endfunction

  // Advance the model with the same inputs the DUTs sample at this edge.
  always @(posedge clk) begin
    mA <= nextModel(mA, 1'b0, fence, flush, gnt, wbe, rst);
    mB <= nextModel(mB, 1'b1, fence, flush, gnt, wbe, rst);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit fe, input bit fl, input bit g, input bit w, input bit r);
    fence = fe;
    flush = fl;
    gnt   = g;
    wbe   = w;
    rst   = r;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("A req",  int'(reqA),  int'(mA.ph == 1));
      checkOutput("A set",  int'(setA),  (mA.ph == 1) ? mA.k / NW : 0);
      checkOutput("A way",  int'(wayA),  (mA.ph == 1) ? mA.k % NW : 0);
      checkOutput("A inv",  int'(invA),  int'(mA.ph == 1));
      checkOutput("A busy", int'(busyA), int'(mA.ph != 0));
      checkOutput("A ack",  int'(ackA),  int'(mA.ph == 3));
      checkOutput("B req",  int'(reqB),  int'(mB.ph == 1));
      checkOutput("B set",  int'(setB),  (mB.ph == 1) ? mB.k / NW : 0);
      checkOutput("B way",  int'(wayB),  (mB.ph == 1) ? mB.k % NW : 0);
      checkOutput("B inv",  int'(invB),  0);
      checkOutput("B busy", int'(busyB), int'(mB.ph != 0));
      checkOutput("B ack",  int'(ackB),  int'(mB.ph == 3));
    end
  end

  int expSet[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int expWay[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int stallIdx[11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};

  // In each directed loop, iteration c runs at the falling edge of cycle c.
  // Inputs applied there are sampled at the rising edge that ends cycle c.
  initial begin
    applyStimulus(0, 0, 1, 1, 1);
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("reset req",  int'(reqA),  0);
    checkOutput("reset set",  int'(setA),  0);
    checkOutput("reset way",  int'(wayA),  0);
    checkOutput("reset inv",  int'(invA),  0);
    checkOutput("reset busy", int'(busyA), 0);
    checkOutput("reset ack",  int'(ackA),  0);
    checkOutput("reset busyB", int'(busyB), 0);
    checkEn = 1'b1;

    // Full walk with grant and drain always ready.
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        checkOutput("walk req", int'(reqA), int'(c >= 1 && c <= 8));
        if (c >= 1 && c <= 8) begin
          checkOutput("walk set", int'(setA), expSet[c-1]);
          checkOutput("walk way", int'(wayA), expWay[c-1]);
        end
        checkOutput("walk ack", int'(ackA), int'(c == 10));
      end
      applyStimulus(0, c == 0, 1, 1, 0);
      @(negedge clk);
    end

    // A fence drains only on A, while B walks the full cache.
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        checkOutput("fence reqA", int'(reqA), 0);
        checkOutput("fence ackA", int'(ackA), int'(c == 2));
        checkOutput("fence ackB", int'(ackB), int'(c == 10));
        if (c == 1) checkOutput("fence reqB", int'(reqB), 1);
      end
      applyStimulus(c == 0, 0, 1, 1, 0);
      @(negedge clk);
    end

    // A fence with a slow write buffer.
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        checkOutput("slowwb ackA",  int'(ackA),  int'(c == 7));
        checkOutput("slowwb busyA", int'(busyA), int'(c <= 7));
      end
      applyStimulus(c == 0, 0, 1, (c >= 6), 0);
      @(negedge clk);
    end

    // Grant withheld for three cycles at line (1,1).
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) begin
        checkOutput("stall req", int'(reqA), int'(c <= 11));
        if (c <= 11) begin
          checkOutput("stall set", int'(setA), stallIdx[c-1] / 2);
          checkOutput("stall way", int'(wayA), stallIdx[c-1] % 2);
        end
        checkOutput("stall ack", int'(ackA), int'(c == 13));
      end
      applyStimulus(0, c == 0, !(c >= 4 && c <= 6), 1, 0);
      @(negedge clk);
    end

    // A fence during a walk is queued, then drained after the first ack.
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) begin
        checkOutput("pendfence ack",  int'(ackA),  int'(c == 10 || c == 12));
        checkOutput("pendfence busy", int'(busyA), int'(c <= 12));
        checkOutput("pendfence req",  int'(reqA),  int'(c <= 8));
        checkOutput("pendfence ackB", int'(ackB),  int'(c == 10 || c == 20));
      end
      applyStimulus(c == 4, c == 0, 1, 1, 0);
      @(negedge clk);
    end

    // Two flushes during a walk coalesce into a single extra walk.
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) begin
        checkOutput("coalesce ack", int'(ackA), int'(c == 10 || c == 20));
        checkOutput("coalesce req", int'(reqA), int'(c <= 8 || (c >= 11 && c <= 18)));
      end
      applyStimulus(0, c == 0 || c == 3 || c == 5, 1, 1, 0);
      @(negedge clk);
    end

    // Reset mid-walk aborts with no ack, and a new flush restarts at (0,0).
    for (int c = 0; c <= 20; c++) begin
      if (c >= 6 && c <= 8) begin
        checkOutput("abort busy", int'(busyA), 0);
        checkOutput("abort req",  int'(reqA),  0);
      end
      if (c == 9) begin
        checkOutput("restart req", int'(reqA), 1);
        checkOutput("restart set", int'(setA), 0);
        checkOutput("restart way", int'(wayA), 0);
      end
      if (c > 0) checkOutput("abort ack", int'(ackA), int'(c == 18));
      applyStimulus(0, c == 0 || c == 8, 1, 1, c == 5);
      @(negedge clk);
    end

    // Randomized traffic, checked by the every-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom % 40 == 0, $urandom % 40 == 0, $urandom % 10 < 7,
                    $urandom % 10 < 6, $urandom % 400 == 0);
      @(negedge clk);
    end

    // Quiet period, which must return both sequencers to idle.
    applyStimulus(0, 0, 1, 1, 0);
    repeat (80) @(negedge clk);
    checkOutput("final busyA", int'(busyA), 0);
    checkOutput("final busyB", int'(busyB), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
